// File: rtl/l2_line_responder.sv
// l2_line_responder: one-entry write-through line buffer answering 128-bit L2 requests from 256-bit physical memory
module l2_line_responder (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  l2cache_address,
  input  logic [127:0] l2cache_wdata,
  input  logic         l2cache_read,
  input  logic         l2cache_write,
  output logic [127:0] l2cache_rdata,
  output logic         l2_resp,
  output logic [15:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  input  logic         pmem_resp
);
  typedef enum logic [2:0] {IDLE, FETCH, WRITEBACK, RESPOND, COOLDOWN} state_t;
  state_t state;
  logic         valid;
  logic [10:0]  tag;
  logic [255:0] line;
  logic [10:0]  req_tag;
  logic         req_half;
  logic [127:0] req_wdata;
  logic         req_is_write;
  logic         hit;
  logic [255:0] fetched;
  logic         unused_ok;
  function automatic logic [255:0] merge(input logic [255:0] l, input logic h, input logic [127:0] d);
    return h ? {d, l[127:0]} : {l[255:128], d};
  endfunction
  function automatic logic [127:0] pick(input logic [255:0] l, input logic h);
    return h ? l[255:128] : l[127:0];
  endfunction
  assign hit        = valid && tag == l2cache_address[15:5];
  assign fetched    = req_is_write ? merge(pmem_rdata, req_half, req_wdata) : pmem_rdata;
  assign pmem_wdata = line;
  assign unused_ok  = ^l2cache_address[3:0];
  // Every output is a flop set on the transition into the state that owns it
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      valid         <= 1'b0;
      tag           <= '0;
      line          <= '0;
      req_tag       <= '0;
      req_half      <= 1'b0;
      req_wdata     <= '0;
      req_is_write  <= 1'b0;
      l2cache_rdata <= '0;
      l2_resp       <= 1'b0;
      pmem_address  <= '0;
      pmem_read     <= 1'b0;
      pmem_write    <= 1'b0;
    end else begin
      l2_resp <= 1'b0;
      case (state)
        IDLE: if (l2cache_read || l2cache_write) begin
          req_tag      <= l2cache_address[15:5];
          req_half     <= l2cache_address[4];
          req_wdata    <= l2cache_wdata;
          req_is_write <= l2cache_write;
          pmem_address <= {l2cache_address[15:5], 5'b0};
          if (!hit) begin
            state     <= FETCH;
            pmem_read <= 1'b1;
          end else if (l2cache_write) begin
            line       <= merge(line, l2cache_address[4], l2cache_wdata);
            state      <= WRITEBACK;
            pmem_write <= 1'b1;
          end else begin
            l2cache_rdata <= pick(line, l2cache_address[4]);
            l2_resp       <= 1'b1;
            state         <= RESPOND;
          end
        end
        FETCH: if (pmem_resp) begin
          line      <= fetched;
          tag       <= req_tag;
          valid     <= 1'b1;
          pmem_read <= 1'b0;
          if (req_is_write) begin
            state      <= WRITEBACK;
            pmem_write <= 1'b1;
          end else begin
            state         <= RESPOND;
            l2_resp       <= 1'b1;
            l2cache_rdata <= pick(fetched, req_half);
          end
        end
        WRITEBACK: if (pmem_resp) begin
          pmem_write    <= 1'b0;
          state         <= RESPOND;
          l2_resp       <= 1'b1;
          l2cache_rdata <= pick(line, req_half);
        end
        RESPOND:  state <= COOLDOWN;
        COOLDOWN: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l2_line_responder.sv
// tb_l2_line_responder: directed and random requests against a flat-memory reference model
module tb_l2_line_responder;
  logic         clk = 0;
  logic         reset = 1;
  logic [15:0]  l2cache_address = '0;
  logic [127:0] l2cache_wdata = '0;
  logic         l2cache_read = 0;
  logic         l2cache_write = 0;
  logic [127:0] l2cache_rdata;
  logic         l2_resp;
  logic [15:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata = '0;
  logic         pmem_read;
  logic         pmem_write;
  logic         pmem_resp = 0;
  int tests = 0, fails = 0;
  logic [255:0] mem [int];
  logic [255:0] ref_mem [int];
  bit rv = 0;
  int rt = 0;
  l2_line_responder dut (
    .clk(clk), .reset(reset), .l2cache_address(l2cache_address), .l2cache_wdata(l2cache_wdata),
    .l2cache_read(l2cache_read), .l2cache_write(l2cache_write), .l2cache_rdata(l2cache_rdata),
    .l2_resp(l2_resp), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp)
  );
  always #5 clk = ~clk;
  function automatic logic [255:0] dflt(input int t);
    return {{4{32'(t) * 32'h9E3779B1}}, {4{32'(t) * 32'h85EBCA6B + 32'd1}}};
  endfunction
  function automatic logic [255:0] env_get(input int t);
    return mem.exists(t) ? mem[t] : dflt(t);
  endfunction
  function automatic logic [255:0] ref_get(input int t);
    return ref_mem.exists(t) ? ref_mem[t] : dflt(t);
  endfunction
  task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask
  task automatic do_req(input bit w, input bit both_lines, input logic [15:0] a, input logic [127:0] d,
                        input int lat_r, input int lat_w, input bit hold);
    int tg, exp_cyc, resp_cyc, rc, wc;
    bit miss, saw_rd, saw_wr, overlap, bad_addr, extra;
    logic [255:0] line, wd;
    logic [127:0] exp_rd, got_rd;
    tg = int'(a[15:5]);
    miss = !rv || rt != tg;
    line = ref_get(tg);
    if (w) begin
      line = a[4] ? {d, line[127:0]} : {line[255:128], d};
      ref_mem[tg] = line;
    end
    rv = 1; rt = tg;
    exp_rd = a[4] ? line[255:128] : line[127:0];
    exp_cyc = (miss ? lat_r : 0) + (w ? lat_w : 0) + 1;
    resp_cyc = 0; rc = 0; wc = 0; saw_rd = 0; saw_wr = 0; overlap = 0; bad_addr = 0; extra = 0;
    wd = '0; got_rd = '0;
    @(negedge clk);
    l2cache_address = a; l2cache_wdata = d; l2cache_write = w; l2cache_read = !w || both_lines;
    for (int c = 1; c <= 60 && resp_cyc == 0; c++) begin
      @(negedge clk);
      pmem_resp = 0;
      if (l2_resp) begin resp_cyc = c; got_rd = l2cache_rdata; end
      if (pmem_read && pmem_write) overlap = 1;
      if ((pmem_read || pmem_write) && pmem_address !== {a[15:5], 5'b0}) bad_addr = 1;
      if (pmem_read) begin
        saw_rd = 1; rc++;
        if (rc == lat_r) begin pmem_resp = 1; pmem_rdata = env_get(int'(pmem_address[15:5])); rc = 0; end
      end
      if (pmem_write) begin
        saw_wr = 1; wd = pmem_wdata; wc++;
        if (wc == lat_w) begin pmem_resp = 1; mem[int'(pmem_address[15:5])] = pmem_wdata; wc = 0; end
      end
    end
    pmem_resp = 0;
    if (hold) begin
      @(negedge clk);
      extra |= l2_resp | pmem_read | pmem_write;
    end
    l2cache_read = 0; l2cache_write = 0;
    repeat (3) begin
      @(negedge clk);
      extra |= l2_resp | pmem_read | pmem_write;
    end
    check("resp_cycle", 256'(resp_cyc), 256'(exp_cyc));
    check("rdata", 256'(got_rd), 256'(exp_rd));
    check("rdata_held", 256'(l2cache_rdata), 256'(exp_rd));
    check("pmem_read_seen", 256'(saw_rd), 256'(miss));
    check("pmem_write_seen", 256'(saw_wr), 256'(w));
    if (w) check("pmem_wdata", wd, line);
    check("rd_wr_overlap", 256'(overlap), 256'(0));
    check("pmem_addr_bad", 256'(bad_addr), 256'(0));
    check("extra_activity", 256'(extra), 256'(0));
  endtask
  initial begin
    logic [15:0] ra;
    bit bad;
    mem[32'h091] = {{32{4'hB}}, {32{4'hA}}};
    ref_mem[32'h091] = mem[32'h091];
    mem[32'h200] = '0;
    ref_mem[32'h200] = '0;
    repeat (3) @(negedge clk);
    check("reset_resp", 256'(l2_resp), 256'(0));
    check("reset_pmem_rw", 256'({pmem_read, pmem_write}), 256'(0));
    check("reset_pmem_addr", 256'(pmem_address), 256'(0));
    check("reset_pmem_wdata", pmem_wdata, 256'(0));
    check("reset_rdata", 256'(l2cache_rdata), 256'(0));
    reset = 0;
    do_req(0, 0, 16'h1230, '0, 4, 1, 0);
    check("tp_miss_rdata", 256'(l2cache_rdata), 256'({32{4'hB}}));
    check("tp_miss_addr", 256'(pmem_address), 256'(16'h1220));
    do_req(0, 0, 16'h1220, '0, 3, 1, 0);
    check("tp_hit_rdata", 256'(l2cache_rdata), 256'({32{4'hA}}));
    do_req(1, 0, 16'h1220, {32{4'hC}}, 1, 2, 0);
    check("tp_wr_hit_mem", mem[32'h091], {{32{4'hB}}, {32{4'hC}}});
    do_req(1, 1, 16'h4010, {32{4'h1}}, 2, 3, 0);
    check("tp_wr_miss_mem", mem[32'h200], {{32{4'h1}}, 128'h0});
    do_req(0, 0, 16'h4000, '0, 2, 1, 0);
    do_req(0, 0, 16'h4010, '0, 2, 1, 1);
    @(negedge clk);
    l2cache_address = 16'h2340; l2cache_read = 1;
    repeat (2) @(negedge clk);
    check("fetch_active", 256'(pmem_read), 256'(1));
    reset = 1; l2cache_read = 0;
    @(negedge clk);
    check("abort_pmem_read", 256'(pmem_read), 256'(0));
    check("abort_resp", 256'(l2_resp), 256'(0));
    reset = 0; rv = 0;
    bad = 0;
    repeat (3) begin @(negedge clk); bad |= l2_resp | pmem_read; end
    check("abort_quiet", 256'(bad), 256'(0));
    do_req(0, 0, 16'h2340, '0, 2, 1, 0);
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: ra[15:5] = 11'h010;
        1: ra[15:5] = 11'h011;
        2: ra[15:5] = 11'h7FF;
        default: ra[15:5] = 11'h091;
      endcase
      ra[4:0] = 5'($urandom);
      do_req(1'($urandom), 1'($urandom), ra, {$urandom, $urandom, $urandom, $urandom},
             $urandom_range(1, 4), $urandom_range(1, 4), 1'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
